// File: rtl/acc_datapath_pkg.sv
// Shared encodings for the accumulator datapath: select codes, ALU ops and the default width.
package acc_datapath_pkg;

  localparam int unsigned ACC_WIDTH = 8;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'b00,
    SEL_SHR  = 2'b01,
    SEL_SHL  = 2'b10,
    SEL_LOAD = 2'b11
  } acc_sel_e;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_AND  = 3'd1,
    ALU_ADD  = 3'd2,
    ALU_SUB  = 3'd3,
    ALU_MUL  = 3'd4,
    ALU_DIV  = 3'd5
  } alu_op_e;

  // Collapse the one-hot op strobes; illegal combinations resolve div > mul > sub > add > and.
  function automatic alu_op_e decode_op(input logic add, input logic sub, input logic and_op,
                                        input logic mul, input logic div);
    alu_op_e op;
    op = ALU_PASS;
    if (div) begin
      op = ALU_DIV;
    end else if (mul) begin
      op = ALU_MUL;
    end else if (sub) begin
      op = ALU_SUB;
    end else if (add) begin
      op = ALU_ADD;
    end else if (and_op) begin
      op = ALU_AND;
    end
    return op;
  endfunction

endpackage

// File: rtl/acc_datapath_alu.sv
// Combinational accumulator ALU: add/sub/and plus multiply and restoring-divide steps.
module acc_alu
  import acc_datapath_pkg::*;
#(
  parameter int unsigned WIDTH = ACC_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  input  logic             mul_bit,
  output logic [WIDTH-1:0] res,
  output logic             cout
);

  localparam int unsigned EW = WIDTH + 1;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           no_borrow;

  assign sum       = EW'(a) + EW'(b);
  assign diff      = EW'(a) - EW'(b);
  assign no_borrow = ~diff[WIDTH];

  always_comb begin : alu_mux
    res  = a;
    cout = 1'b0;
    case (op)
      ALU_ADD: begin
        res  = sum[WIDTH-1:0];
        cout = sum[WIDTH];
      end
      ALU_SUB: begin
        res  = diff[WIDTH-1:0];
        cout = no_borrow;
      end
      ALU_AND: begin
        res = a & b;
      end
      ALU_MUL: begin
        if (mul_bit) begin
          res  = sum[WIDTH-1:0];
          cout = sum[WIDTH];
        end
      end
      ALU_DIV: begin
        if (no_borrow) begin
          res  = diff[WIDTH-1:0];
          cout = 1'b1;
        end
      end
      default: begin
        res  = a;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/acc_datapath.sv
// Accumulator datapath: ah/al/carry registers driven by the per-T-state control word.
// Optional macro ACC_FLAG_REG_EN registers zero_flag/sign_flag alongside ah.
module acc_datapath
  import acc_datapath_pkg::*;
#(
  parameter int unsigned WIDTH = ACC_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] bus_in,
  input  logic [WIDTH-1:0] breg_data,
  input  logic [1:0]       acc_high_select,
  input  logic [1:0]       acc_low_select,
  input  logic             acc_in_select,
  input  logic             acc_high_reset_p,
  input  logic             op_add,
  input  logic             op_sub,
  input  logic             op_and,
  input  logic             op_mul,
  input  logic             op_div,
  input  logic             acc_oen,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_out_valid,
  output logic [WIDTH-1:0] acc_low,
  output logic             zero_flag,
  output logic             sign_flag,
  output logic             carry_flag
);

  acc_sel_e         high_sel;
  acc_sel_e         low_sel;
  alu_op_e          alu_op;
  logic [WIDTH-1:0] ah;
  logic [WIDTH-1:0] al;
  logic [WIDTH-1:0] ah_next;
  logic [WIDTH-1:0] al_next;
  logic [WIDTH-1:0] alu_res;
  logic             carry;
  logic             carry_next;
  logic             alu_cout;

  assign high_sel = acc_sel_e'(acc_high_select);
  assign low_sel  = acc_sel_e'(acc_low_select);
  assign alu_op   = decode_op(op_add, op_sub, op_and, op_mul, op_div);

  acc_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a      (ah),
    .b      (breg_data),
    .op     (alu_op),
    .mul_bit(al[0]),
    .res    (alu_res),
    .cout   (alu_cout)
  );

  // High half and carry; the carry only follows the ALU when an op is actually selected.
  always_comb begin : ah_next_logic
    ah_next    = ah;
    carry_next = carry;
    if (acc_high_reset_p) begin
      ah_next    = '0;
      carry_next = 1'b0;
    end else begin
      case (high_sel)
        SEL_HOLD: ah_next = ah;
        SEL_SHR:  ah_next = {carry, ah[WIDTH-1:1]};
        SEL_SHL:  ah_next = {ah[WIDTH-2:0], al[WIDTH-1]};
        SEL_LOAD: begin
          if (acc_in_select) begin
            ah_next = bus_in;
          end else begin
            ah_next = alu_res;
            if (alu_op != ALU_PASS) begin
              carry_next = alu_cout;
            end
          end
        end
        default: ah_next = ah;
      endcase
    end
  end

  // Low half; left shift pulls in the carry so a divide step deposits its quotient bit.
  always_comb begin : al_next_logic
    al_next = al;
    case (low_sel)
      SEL_HOLD: al_next = al;
      SEL_SHR:  al_next = {ah[0], al[WIDTH-1:1]};
      SEL_SHL:  al_next = {al[WIDTH-2:0], carry};
      SEL_LOAD: al_next = ah;
      default:  al_next = al;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin : acc_regs
    if (!reset_n) begin
      ah    <= '0;
      al    <= '0;
      carry <= 1'b0;
    end else begin
      ah    <= ah_next;
      al    <= al_next;
      carry <= carry_next;
    end
  end

`ifdef ACC_FLAG_REG_EN
  logic zero_q;
  logic sign_q;

  always_ff @(posedge clk or negedge reset_n) begin : flag_regs
    if (!reset_n) begin
      zero_q <= 1'b1;
      sign_q <= 1'b0;
    end else begin
      zero_q <= (ah_next == '0);
      sign_q <= ah_next[WIDTH-1];
    end
  end

  assign zero_flag = zero_q;
  assign sign_flag = sign_q;
`else
  assign zero_flag = (ah == '0);
  assign sign_flag = ah[WIDTH-1];
`endif

  assign bus_out       = acc_oen ? ah : '0;
  assign bus_out_valid = acc_oen;
  assign acc_low       = al;
  assign carry_flag    = carry;

endmodule
